// File: rtl/cog_mdu.sv
// cog_mdu: radix-2 iterative multiply/divide unit with start/busy/done handshake and C/Z flags
module cog_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_cog,
  input  logic             nres,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r_lo,
  output logic [WIDTH-1:0] r_hi,
  output logic             co,
  output logic             zo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d, d_q, d_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic               busy_q, busy_d, done_q, done_d, co_q, co_d, zo_q, zo_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               sd, ss, div_ge;
  logic [WIDTH-1:0]   dm, sm, quo, rem, lo_n, hi_n;
  logic [WIDTH:0]     mul_sum, div_t, div_r;
  logic [2*WIDTH-1:0] prod;
  logic               co_n;
  always_comb begin
    sd      = op[0] & d[WIDTH-1];
    ss      = op[0] & s[WIDTH-1];
    dm      = sd ? -d : d;
    sm      = ss ? -s : s;
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, b_q} & {(WIDTH+1){acc_q[0]}});
    div_t   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge  = div_t >= {1'b0, b_q};
    div_r   = div_ge ? div_t - {1'b0, b_q} : div_t;
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    lo_n    = !op_q[1] ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : quo;
    hi_n    = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : dz_q ? d_q : rem;
    co_n    = !op_q[1] ? (op_q[0] ? hi_n != {WIDTH{lo_n[WIDTH-1]}} : hi_n != '0) : (dz_q | ovf_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    d_d     = d_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    co_d    = co_q;
    zo_d    = zo_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d = RUN;
        cnt_d   = '0;
        busy_d  = 1'b1;
        op_d    = op;
        b_d     = op[1] ? sm : dm;
        acc_d   = {{WIDTH{1'b0}}, op[1] ? dm : sm};
        neg_d   = sd ^ ss;
        rneg_d  = sd;
        d_d     = d;
        dz_d    = s == '0;
        ovf_d   = op == 2'b11 && d == {1'b1, {(WIDTH-1){1'b0}}} && &s;
      end
    end else if (state_q == RUN) begin
      acc_d = op_q[1] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge} : {mul_sum, acc_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
    end else begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      lo_d    = lo_n;
      hi_d    = hi_n;
      co_d    = co_n;
      zo_d    = lo_n == '0;
    end
  end
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      co_q    <= 1'b0;
      zo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      co_q    <= co_d;
      zo_q    <= zo_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign r_lo = lo_q;
  assign r_hi = hi_q;
  assign co   = co_q;
  assign zo   = zo_q;
endmodule

// File: tb/tb_cog_mdu.sv
// tb_cog_mdu: scoreboard bench for cog_mdu with directed vectors and handshake scenarios
module tb_cog_mdu;
  localparam int W = 32;
  logic         clk_cog = 1'b0;
  logic         nres = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] s = '0, d = '0;
  logic         busy, done, co, zo;
  logic [W-1:0] r_lo, r_hi;
  typedef struct {logic [W-1:0] lo; logic [W-1:0] hi; logic c; logic z;} exp_t;
  exp_t exp_q[$];
  exp_t last, m_e;
  int errors = 0, checks = 0;

  cog_mdu #(.WIDTH(W)) dut (
    .clk_cog(clk_cog), .nres(nres), .start(start), .abort(abort), .op(op), .s(s), .d(d),
    .busy(busy), .done(done), .r_lo(r_lo), .r_hi(r_hi), .co(co), .zo(zo)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_cog) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got r_lo=%h r_hi=%h with no pending op", r_lo, r_hi);
      end else begin
        m_e = exp_q.pop_front();
        chk("r_lo", 64'(r_lo), 64'(m_e.lo));
        chk("r_hi", 64'(r_hi), 64'(m_e.hi));
        chk("co", 64'(co), 64'(m_e.c));
        chk("zo", 64'(zo), 64'(m_e.z));
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] dd, input logic [W-1:0] ss,
                        input bit push, input logic [W-1:0] lo, input logic [W-1:0] hi,
                        input logic c, input logic z);
    op = o; d = dd; s = ss; start = 1'b1;
    if (push) begin
      exp_q.push_back('{lo, hi, c, z});
      last = '{lo, hi, c, z};
    end
    @(posedge clk_cog); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    for (n = base + 1; n <= 100; n++) begin
      @(posedge clk_cog); #1;
      if (n == W) chk("busy_before_done", 64'(busy), 64'd1);
      if (done) break;
    end
    chk("latency", 64'(n), 64'(W + 1));
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_r_lo"}, 64'(r_lo), 64'd0);
    chk({tag, "_r_hi"}, 64'(r_hi), 64'd0);
    chk({tag, "_co"}, 64'(co), 64'd0);
    chk({tag, "_zo"}, 64'(zo), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk_cog);
    #1 check_zero("reset");
    @(negedge clk_cog) nres = 1'b1;
    @(negedge clk_cog);
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 32'hFFFFFFFE, 1, 0);
    wait_done(0);
    // Back-to-back: launched while done is high
    launch(2'b01, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b01, 32'h40000000, 32'd4, 1, 32'h00000000, 32'h00000001, 1, 1);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b11, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
    wait_done(0);
    // A start pulsed at iteration 10 must be ignored
    @(negedge clk_cog);
    launch(2'b10, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 0);
    repeat (9) @(posedge clk_cog);
    #1 begin op = 2'b00; d = 32'd5; s = 32'd5; start = 1'b1; end
    @(posedge clk_cog); #1 start = 1'b0;
    wait_done(10);
    repeat (40) @(posedge clk_cog);
    #1 chk("ignored_start_idle", 64'(busy), 64'd0);
    @(negedge clk_cog);
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h00000000, 1, 0);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b10, 32'd5, 32'd9, 1, 32'd0, 32'd5, 0, 1);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b11, 32'd7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 32'd1, 0, 0);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b01, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h00000000, 1, 0);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b00, 32'h1234, 32'h10, 1, 32'h00012340, 32'h00000000, 0, 0);
    wait_done(0);
    // Abort mid-run: results from the previous op must survive
    @(negedge clk_cog);
    launch(2'b10, 32'h1234, 32'd3, 0, '0, '0, 0, 0);
    repeat (5) @(posedge clk_cog);
    #1 abort = 1'b1;
    @(posedge clk_cog); #1 abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_r_lo", 64'(r_lo), 64'(last.lo));
    chk("abort_r_hi", 64'(r_hi), 64'(last.hi));
    chk("abort_co", 64'(co), 64'(last.c));
    repeat (40) @(posedge clk_cog);
    #1 chk("abort_idle", 64'(busy), 64'd0);
    @(negedge clk_cog);
    launch(2'b11, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 0);
    wait_done(0);
    @(negedge clk_cog);
    launch(2'b10, 32'h1234, 32'd0, 1, 32'hFFFFFFFF, 32'h00001234, 1, 0);
    wait_done(0);
    // Asynchronous reset mid-run, checked before any further clock edge
    @(negedge clk_cog);
    launch(2'b00, 32'd9, 32'd9, 0, '0, '0, 0, 0);
    repeat (7) @(posedge clk_cog);
    #3 nres = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk_cog) nres = 1'b1;
    @(negedge clk_cog);
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 32'h00000000, 0, 0);
    wait_done(0);
    repeat (3) @(posedge clk_cog);
    #1 chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cog_mdu.md
Name: cog_mdu

Overview:
- Parametrised iterative multiply/divide unit for the cog datapath, alongside the combinational ALU.
- Handles the multi-cycle ops that the single-cycle ALU cannot: unsigned/signed multiply and unsigned/signed divide with remainder.
- Produces C/Z flags in the same style as the ALU. Results are held until the next start.
- Radix-2, one bit per clock. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- CW, $clog2(WIDTH+1), iteration counter width; derived localparam, not overridable.

Ports:
- clk_cog  in  1  cog clock, rising edge
- nres  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE
- op  in  2  00=MUL, 01=MULS, 10=DIV, 11=DIVS
- s  in  WIDTH  source: multiplier or divisor
- d  in  WIDTH  destination: multiplicand or dividend
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are valid
- r_lo  out  WIDTH  MUL: low product; DIV: quotient
- r_hi  out  WIDTH  MUL: high product; DIV: remainder
- co  out  1  carry/error flag
- zo  out  1  zero flag

Behaviour:
- Reset (nres=0, asynchronous): state=IDLE; busy=0, done=0, r_lo=0, r_hi=0, co=0, zo=0; counter=0.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start=1 and abort=0, capture op, s and d.
  - Signed ops store absolute values and record result-sign bits.
  - Go to RUN with counter=0 and busy=1.
  - done drops to 0 on the first clock after its pulse.
- RUN, one iteration per clock, counter increments; after WIDTH iterations go to FIX.
  - MUL: shift-add into a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract; one quotient bit per clock.
- FIX, one clock:
  - Apply sign correction and register r_lo, r_hi, co and zo.
  - Assert done=1, deassert busy, return to IDLE.
- Latency: done is high in the cycle following edge WIDTH+1, counting the edge that samples start as edge 0. Latency is fixed for every op, including the special cases.
- Outputs hold their value until the next FIX. Between operations they change only on reset.
- start while busy=1 is ignored, and no queueing occurs. start on the same cycle as the done pulse is accepted, because the block is in IDLE then.
- abort=1 in RUN or FIX:
  - Next state is IDLE; busy=0, done=0.
  - Result outputs keep their previous values.
  - abort has priority over start.
- Signed rules:
  - MULS: product sign = d[MSB]^s[MSB]; the full 2*WIDTH product is two's-complement.
  - DIVS: quotient sign = d[MSB]^s[MSB]; remainder takes the dividend's sign (truncating division).
- Flags:
  - MUL: co=(r_hi!=0).
  - MULS: co=(r_hi is not all copies of r_lo[MSB]), i.e. the result does not fit in WIDTH bits.
  - DIV/DIVS: co=0 unless a special case below applies.
  - zo=(r_lo==0) for all ops.
- Divide by zero (s==0, DIV or DIVS): r_lo=all ones, r_hi=d as input, co=1. Normal latency applies.
- DIVS overflow (d=MIN, s=-1): r_lo=MIN, r_hi=0, co=1.
- All arithmetic is modulo 2^WIDTH per half. There are no X outputs for any input combination.

Test Plan:
- WIDTH=32, MUL: d=0xFFFFFFFF, s=0xFFFFFFFF -> r_hi=0xFFFFFFFE, r_lo=0x00000001, co=1, zo=0. done exactly 33 edges after start (edge WIDTH+1); busy high for the 32 cycles before it.
- MULS: d=-3, s=7 -> r_lo=0xFFFFFFEB, r_hi=0xFFFFFFFF, co=0.
- MULS: d=0x40000000, s=4 -> r_lo=0, r_hi=1, co=1, zo=1.
- DIVS: d=-7, s=2 -> r_lo=0xFFFFFFFD (-3), r_hi=0xFFFFFFFF (-1), co=0.
- DIV: d=0x1234, s=0 -> r_lo=0xFFFFFFFF, r_hi=0x1234, co=1.
- DIVS: d=0x80000000, s=0xFFFFFFFF -> r_lo=0x80000000, r_hi=0, co=1.
- Handshake:
  - start pulsed at iteration 10 is ignored.
  - abort at iteration 5 -> busy=0 next cycle, no done pulse, previous results unchanged.
  - Back-to-back start in the done cycle is accepted.
  - nres low mid-RUN clears all outputs immediately, without waiting for a clock edge.
